dispatch_issue: RTL and testbench
=================================

// Module: dispatch_issue
// PURPOSE
//  Dual-issue dispatch stage, directly downstream of the decoder's decode queue.
//  Each cycle it examines the two oldest decoded instructions (slot0 = older)
//  and issues 0, 1 or 2 of them in order into a registered execute-stage bundle.
//  Issue decisions account for intra-pair dependencies, load-use hazards and
//  single-issue instructions. Pop acknowledges return to the queue on dequeue_en.
// PARAMETERS
//  PAYLOAD_W    120  opaque pass-through bits per slot {imm,alusel,aluop,inst,pc}
//  DUAL_ISSUE   1    1 = dual issue allowed; 0 = slot1 never issues
//  PERF_W       32   width of the performance counters
// PORTS
//  clk            in   1             clock, rising edge
//  rst            in   1             reset, asynchronous, active-low
//  flush          in   1             pipeline flush (branch mispredict / exception)
//  ex_stall       in   1             execute stage cannot accept new bundle
//  id_valid       in   2             queue head entries valid; [0] = oldest
//  id_payload     in   2xPAYLOAD_W   pass-through decoded fields per slot
//  id_rd_en       in   2x2           per slot: {reg2_read_en, reg1_read_en}
//  id_rd_addr     in   2x2x5         per slot: {reg2 addr, reg1 addr}
//  id_wen         in   2             GPR write enable per slot
//  id_waddr       in   2x5           GPR destination per slot
//  id_is_load     in   2             slot is a load
//  id_single      in   2             must issue alone: privileged/CSR/exception/branch
//  dequeue_en     out  2             pop acknowledge to decode queue (comb.)
//  ex_valid       out  2             issued bundle valid bits
//  ex_payload     out  2xPAYLOAD_W   registered payload
//  ex_rd_en       out  2x2           registered read enables
//  ex_rd_addr     out  2x2x5         registered read addresses
//  ex_wen         out  2             registered write enables
//  ex_waddr       out  2x5           registered destinations
//  ex_is_load     out  2             registered load flags
//  perf_dual_cnt  out  PERF_W        cycles in which two instructions issued
//  perf_stall_cnt out  PERF_W        cycles in which slot0 was valid but not issued
// BEHAVIOUR
//  - Reset (rst=0, async): all ex_* = 0, counters = 0; dequeue_en = 0 while rst low.
//  - lu[k] (load-use), for slot k: some ex slot j has ex_valid[j] & ex_is_load[j] &
//    ex_wen[j] & ex_waddr[j]!=0 & ex_waddr[j] == an enabled id_rd_addr[k].
//  - raw01: id_wen[0] & id_waddr[0]!=0 & slot1 reads id_waddr[0] (any enabled port).
//  - waw01: id_wen[0] & id_wen[1] & id_waddr[0]==id_waddr[1].
//  - issue0 = id_valid[0] & !flush & !ex_stall & !lu[0].
//  - issue1 = issue0 & DUAL_ISSUE & id_valid[1] & !id_single[0] & !id_single[1]
//    & !lu[1] & !raw01 & !waw01.
//  - dequeue_en = {issue1, issue0}, combinational; the queue pops on the same edge.
//    Slot1 is never popped without slot0. id_valid = 10 is ignored (no issue).
//  - Register r0 never causes a hazard.
//  - Posedge priority:
//    - flush: ex_valid <= 00.
//    - else ex_stall: all ex_* hold.
//    - else: ex_valid <= {issue1, issue0}; issued slots load their id_* fields;
//      non-issued slots load zeros.
//  - Latency: queue head to ex_* is 1 cycle. A load-use hazard inserts exactly one
//    bubble (ex_valid=00); on the following cycle the load has left ex_*.
//  - Counters (wrap modulo 2^PERF_W, not cleared by flush):
//    - perf_dual_cnt += issue1.
//    - perf_stall_cnt += id_valid[0] & !issue0 & !flush.
// TESTING
//  1 Reset: rst low mid-stream with ex_valid=11 -> ex_valid=00 and counters=0
//    immediately, without a clock edge; dequeue_en=00 until rst is released.
//  2 Independent pair: add r1,r3,r4 / add r2,r5,r6 -> dequeue_en=11; next cycle
//    ex_valid=11, ex_waddr={2,1}, perf_dual_cnt=1.
//  3 RAW: slot0 writes r5, slot1 reads r5 -> dequeue_en=01, ex_valid=01; next cycle
//    that instruction issues from slot0. A pair where both write r7 behaves the same.
//  4 Load-use: ld.w r6 issued; next head slot0 reads r6 -> dequeue_en=00, bubble
//    ex_valid=00, perf_stall_cnt+1, then issue. A load to r0 followed by a read of r0
//    issues without a stall.
//  5 Stall/flush: ex_valid=11 and ex_stall held 3 cycles -> ex_* stable,
//    dequeue_en=00; flush asserted during the stall -> ex_valid=00 at the next edge.
//  6 Single: id_single[0]=1 (csrwr) with valid pair -> dequeue_en=01. id_single[1]=1
//    -> slot0 issues alone, then the csrwr issues alone. DUAL_ISSUE=0 -> never 11.

Source files
------------

// File: rtl/dispatch_issue.sv
// Dual-issue dispatch stage: picks 0..2 in-order instructions from the decode queue head
// and registers them into the execute-stage bundle, with load-use and intra-pair hazard checks.
module dispatch_issue #(
   parameter int PAYLOAD_W  = 120,
   parameter bit DUAL_ISSUE = 1'b1,
   parameter int PERF_W     = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      ex_stall_i,
   input  logic [1:0]                id_valid_i,
   input  logic [1:0][PAYLOAD_W-1:0] id_payload_i,
   input  logic [1:0][1:0]           id_rd_en_i,
   input  logic [1:0][1:0][4:0]      id_rd_addr_i,
   input  logic [1:0]                id_wen_i,
   input  logic [1:0][4:0]           id_waddr_i,
   input  logic [1:0]                id_is_load_i,
   input  logic [1:0]                id_single_i,
   output logic [1:0]                dequeue_en_o,
   output logic [1:0]                ex_valid_o,
   output logic [1:0][PAYLOAD_W-1:0] ex_payload_o,
   output logic [1:0][1:0]           ex_rd_en_o,
   output logic [1:0][1:0][4:0]      ex_rd_addr_o,
   output logic [1:0]                ex_wen_o,
   output logic [1:0][4:0]           ex_waddr_o,
   output logic [1:0]                ex_is_load_o,
   output logic [PERF_W-1:0]         perf_dual_cnt_o,
   output logic [PERF_W-1:0]         perf_stall_cnt_o
);

   logic [1:0]                valid_q, valid_d;
   logic [1:0][PAYLOAD_W-1:0] payload_q, payload_d;
   logic [1:0][1:0]           rd_en_q, rd_en_d;
   logic [1:0][1:0][4:0]      rd_addr_q, rd_addr_d;
   logic [1:0]                wen_q, wen_d;
   logic [1:0][4:0]           waddr_q, waddr_d;
   logic [1:0]                is_load_q, is_load_d;
   logic [PERF_W-1:0]         dual_cnt_q, dual_cnt_d;
   logic [PERF_W-1:0]         stall_cnt_q, stall_cnt_d;

   logic [1:0] lu;
   logic       raw01;
   logic       waw01;
   logic       issue0;
   logic       issue1;

   // A load still sitting in ex_* has no result yet for a reader at the queue head.
   always_comb begin
      lu = '0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 2; j++) begin
            for (int p = 0; p < 2; p++) begin
               if (valid_q[j] && is_load_q[j] && wen_q[j] && (waddr_q[j] != 5'd0) &&
                   id_rd_en_i[k][p] && (id_rd_addr_i[k][p] == waddr_q[j]))
                  lu[k] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      raw01 = 1'b0;
      for (int p = 0; p < 2; p++) begin
         if (id_wen_i[0] && (id_waddr_i[0] != 5'd0) && id_rd_en_i[1][p] &&
             (id_rd_addr_i[1][p] == id_waddr_i[0]))
            raw01 = 1'b1;
      end
   end

   // Writes to r0 are discarded, so a shared r0 destination is not an ordering hazard.
   assign waw01 = id_wen_i[0] && id_wen_i[1] && (id_waddr_i[0] == id_waddr_i[1]) &&
                  (id_waddr_i[0] != 5'd0);

   assign issue0 = id_valid_i[0] && !flush_i && !ex_stall_i && !lu[0];
   assign issue1 = issue0 && DUAL_ISSUE && id_valid_i[1] && !id_single_i[0] &&
                   !id_single_i[1] && !lu[1] && !raw01 && !waw01;

   assign dequeue_en_o = rst_ni ? {issue1, issue0} : 2'b00;

   always_comb begin
      valid_d     = valid_q;
      payload_d   = payload_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      wen_d       = wen_q;
      waddr_d     = waddr_q;
      is_load_d   = is_load_q;
      dual_cnt_d  = dual_cnt_q + PERF_W'(issue1);
      stall_cnt_d = stall_cnt_q + PERF_W'(id_valid_i[0] && !issue0 && !flush_i);
      if (flush_i) begin
         valid_d = 2'b00;
      end else if (!ex_stall_i) begin
         valid_d = {issue1, issue0};
         for (int k = 0; k < 2; k++) begin
            payload_d[k] = valid_d[k] ? id_payload_i[k] : '0;
            rd_en_d[k]   = valid_d[k] ? id_rd_en_i[k] : '0;
            rd_addr_d[k] = valid_d[k] ? id_rd_addr_i[k] : '0;
            wen_d[k]     = valid_d[k] ? id_wen_i[k] : 1'b0;
            waddr_d[k]   = valid_d[k] ? id_waddr_i[k] : 5'd0;
            is_load_d[k] = valid_d[k] ? id_is_load_i[k] : 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q     <= '0;
         payload_q   <= '0;
         rd_en_q     <= '0;
         rd_addr_q   <= '0;
         wen_q       <= '0;
         waddr_q     <= '0;
         is_load_q   <= '0;
         dual_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         payload_q   <= payload_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         wen_q       <= wen_d;
         waddr_q     <= waddr_d;
         is_load_q   <= is_load_d;
         dual_cnt_q  <= dual_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid_o       = valid_q;
   assign ex_payload_o     = payload_q;
   assign ex_rd_en_o       = rd_en_q;
   assign ex_rd_addr_o     = rd_addr_q;
   assign ex_wen_o         = wen_q;
   assign ex_waddr_o       = waddr_q;
   assign ex_is_load_o     = is_load_q;
   assign perf_dual_cnt_o  = dual_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dispatch_issue.sv
// Bench for dispatch_issue: directed hazard scenarios plus randomized traffic
// checked against a rule-level reference model of the issue decision and ex bundle.
module tb_dispatch_issue;

   localparam int PW = 120;
   localparam int CW = 32;

   logic                clk_sys = 1'b0;
   logic                rst_n;
   logic                flush, ex_stall;
   logic [1:0]          id_valid;
   logic [1:0][PW-1:0]  id_payload;
   logic [1:0][1:0]     id_rd_en;
   logic [1:0][1:0][4:0] id_rd_addr;
   logic [1:0]          id_wen;
   logic [1:0][4:0]     id_waddr;
   logic [1:0]          id_is_load, id_single;

   logic [1:0]          dequeue_en, ex_valid, ex_wen, ex_is_load;
   logic [1:0][PW-1:0]  ex_payload;
   logic [1:0][1:0]     ex_rd_en;
   logic [1:0][1:0][4:0] ex_rd_addr;
   logic [1:0][4:0]     ex_waddr;
   logic [CW-1:0]       perf_dual, perf_stall;

   logic [1:0]          dq2, exv2, exw2, exl2;
   logic [1:0][PW-1:0]  exp2;
   logic [1:0][1:0]     exre2;
   logic [1:0][1:0][4:0] exra2;
   logic [1:0][4:0]     exwa2;
   logic [CW-1:0]       pd2, ps2;

   always #5 clk_sys = ~clk_sys;

   dispatch_issue #(.PAYLOAD_W(PW), .DUAL_ISSUE(1'b1), .PERF_W(CW)) u_dut (
      .clk_i(clk_sys), .rst_ni(rst_n), .flush_i(flush), .ex_stall_i(ex_stall),
      .id_valid_i(id_valid), .id_payload_i(id_payload), .id_rd_en_i(id_rd_en),
      .id_rd_addr_i(id_rd_addr), .id_wen_i(id_wen), .id_waddr_i(id_waddr),
      .id_is_load_i(id_is_load), .id_single_i(id_single), .dequeue_en_o(dequeue_en),
      .ex_valid_o(ex_valid), .ex_payload_o(ex_payload), .ex_rd_en_o(ex_rd_en),
      .ex_rd_addr_o(ex_rd_addr), .ex_wen_o(ex_wen), .ex_waddr_o(ex_waddr),
      .ex_is_load_o(ex_is_load), .perf_dual_cnt_o(perf_dual), .perf_stall_cnt_o(perf_stall)
   );

   dispatch_issue #(.PAYLOAD_W(PW), .DUAL_ISSUE(1'b0), .PERF_W(CW)) u_single (
      .clk_i(clk_sys), .rst_ni(rst_n), .flush_i(flush), .ex_stall_i(ex_stall),
      .id_valid_i(id_valid), .id_payload_i(id_payload), .id_rd_en_i(id_rd_en),
      .id_rd_addr_i(id_rd_addr), .id_wen_i(id_wen), .id_waddr_i(id_waddr),
      .id_is_load_i(id_is_load), .id_single_i(id_single), .dequeue_en_o(dq2),
      .ex_valid_o(exv2), .ex_payload_o(exp2), .ex_rd_en_o(exre2),
      .ex_rd_addr_o(exra2), .ex_wen_o(exw2), .ex_waddr_o(exwa2),
      .ex_is_load_o(exl2), .perf_dual_cnt_o(pd2), .perf_stall_cnt_o(ps2)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the execute bundle as a pair of instruction records.
   typedef struct {
      logic          valid;
      logic [PW-1:0] payload;
      logic [1:0]    rd_en;
      logic [4:0]    ra [2];
      logic          wen;
      logic [4:0]    waddr;
      logic          is_load;
   } inst_t;

   inst_t     m_ex [2];
   int unsigned m_dual, m_stall;
   logic [1:0] last_dq;

   function automatic bit slot_reads(int k, logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      for (int p = 0; p < 2; p++)
         if (id_rd_en[k][p] && id_rd_addr[k][p] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit waits_on_load(int k);
      foreach (m_ex[j])
         if (m_ex[j].valid && m_ex[j].is_load && m_ex[j].wen && slot_reads(k, m_ex[j].waddr))
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] model_issue();
      bit first, second;
      bit pair_dep;
      first = id_valid[0] && !flush && !ex_stall && !waits_on_load(0);
      pair_dep = (id_wen[0] && slot_reads(1, id_waddr[0])) ||
                 (id_wen[0] && id_wen[1] && id_waddr[0] == id_waddr[1] && id_waddr[0] != 0);
      second = first && id_valid[1] && !id_single[0] && !id_single[1] &&
               !waits_on_load(1) && !pair_dep;
      return {second, first};
   endfunction

   function automatic void model_reset();
      foreach (m_ex[j]) begin
         m_ex[j].valid = 0; m_ex[j].payload = '0; m_ex[j].rd_en = 0;
         m_ex[j].ra[0] = 0; m_ex[j].ra[1] = 0; m_ex[j].wen = 0;
         m_ex[j].waddr = 0; m_ex[j].is_load = 0;
      end
      m_dual = 0; m_stall = 0;
   endfunction

   function automatic void model_clock(logic [1:0] iss);
      m_dual  += int'(iss[1]);
      m_stall += int'(id_valid[0] && !iss[0] && !flush);
      if (flush) begin
         m_ex[0].valid = 0; m_ex[1].valid = 0;
      end else if (!ex_stall) begin
         foreach (m_ex[k]) begin
            if (iss[k]) begin
               m_ex[k].valid = 1; m_ex[k].payload = id_payload[k]; m_ex[k].rd_en = id_rd_en[k];
               m_ex[k].ra[0] = id_rd_addr[k][0]; m_ex[k].ra[1] = id_rd_addr[k][1];
               m_ex[k].wen = id_wen[k]; m_ex[k].waddr = id_waddr[k]; m_ex[k].is_load = id_is_load[k];
            end else begin
               m_ex[k].valid = 0; m_ex[k].payload = '0; m_ex[k].rd_en = 0;
               m_ex[k].ra[0] = 0; m_ex[k].ra[1] = 0; m_ex[k].wen = 0;
               m_ex[k].waddr = 0; m_ex[k].is_load = 0;
            end
         end
      end
   endfunction

   function automatic logic [PW-1:0] rand_payload();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[PW-1:0];
   endfunction

   task automatic clear_inputs();
      flush = 0; ex_stall = 0; id_valid = 0; id_payload = '0; id_rd_en = '0;
      id_rd_addr = '0; id_wen = 0; id_waddr = '0; id_is_load = 0; id_single = 0;
   endtask

   task automatic set_slot(input int k, input logic wen, input logic [4:0] wa,
                           input logic en1, input logic [4:0] r1, input logic en2,
                           input logic [4:0] r2, input logic ld, input logic sgl);
      id_valid[k] = 1'b1; id_payload[k] = rand_payload();
      id_wen[k] = wen; id_waddr[k] = wa; id_rd_en[k] = {en2, en1};
      id_rd_addr[k][0] = r1; id_rd_addr[k][1] = r2; id_is_load[k] = ld; id_single[k] = sgl;
   endtask

   // One clock: inputs are already set after a negedge; check the pop decision
   // before the edge and the registered bundle after it.
   task automatic cyc();
      logic [1:0] iss;
      #2;
      iss = model_issue();
      chk("dequeue_en", 256'(dequeue_en), 256'(iss));
      if (dq2[1] !== 1'b0) chk("single_cfg_slot1", 256'(dq2[1]), 256'(0));
      last_dq = dequeue_en;
      @(posedge clk_sys);
      model_clock(iss);
      #1;
      chk("ex_valid", 256'(ex_valid), 256'({m_ex[1].valid, m_ex[0].valid}));
      chk("ex_payload", 256'(ex_payload), 256'({m_ex[1].payload, m_ex[0].payload}));
      chk("ex_regs", 256'({ex_rd_en, ex_rd_addr, ex_wen, ex_waddr, ex_is_load}),
          256'({m_ex[1].rd_en, m_ex[0].rd_en, m_ex[1].ra[1], m_ex[1].ra[0], m_ex[0].ra[1],
                m_ex[0].ra[0], m_ex[1].wen, m_ex[0].wen, m_ex[1].waddr, m_ex[0].waddr,
                m_ex[1].is_load, m_ex[0].is_load}));
      chk("perf_dual", 256'(perf_dual), 256'(m_dual));
      chk("perf_stall", 256'(perf_stall), 256'(m_stall));
      @(negedge clk_sys);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      last_dq = 0;
      rst_n = 0;
      #1;
      chk("reset_ex_valid", 256'(ex_valid), 256'(0));
      chk("reset_counters", 256'({perf_dual, perf_stall}), 256'(0));
      @(negedge clk_sys); @(negedge clk_sys);
      rst_n = 1;

      // Independent pair: add r1,r3,r4 / add r2,r5,r6
      set_slot(0, 1, 5'd1, 1, 5'd3, 1, 5'd4, 0, 0);
      set_slot(1, 1, 5'd2, 1, 5'd5, 1, 5'd6, 0, 0);
      cyc();
      chk("pair_dq", 256'(last_dq), 256'(2'b11));
      chk("pair_waddr", 256'(ex_waddr), 256'({5'd2, 5'd1}));
      chk("pair_dual", 256'(perf_dual), 256'(1));

      // Asynchronous reset mid-stream while the bundle is full
      #3;
      rst_n = 0;
      #1;
      chk("async_rst_valid", 256'(ex_valid), 256'(0));
      chk("async_rst_cnt", 256'({perf_dual, perf_stall}), 256'(0));
      chk("rst_dq_low", 256'(dequeue_en), 256'(0));
      @(posedge clk_sys); #1;
      chk("rst_dq_held", 256'(dequeue_en), 256'(0));
      chk("rst_valid_held", 256'(ex_valid), 256'(0));
      model_reset();
      @(negedge clk_sys);
      rst_n = 1;
      clear_inputs();

      // RAW inside the pair: slot1 reads r5 written by slot0
      set_slot(0, 1, 5'd5, 1, 5'd1, 0, 5'd0, 0, 0);
      set_slot(1, 1, 5'd8, 1, 5'd5, 1, 5'd2, 0, 0);
      cyc();
      chk("raw_dq", 256'(last_dq), 256'(2'b01));
      id_payload[0] = id_payload[1]; id_wen[0] = 1; id_waddr[0] = 5'd8;
      id_rd_en[0] = 2'b11; id_rd_addr[0] = id_rd_addr[1]; id_valid = 2'b01;
      cyc();
      chk("raw_second", 256'({ex_valid, ex_waddr[0]}), 256'({2'b01, 5'd8}));

      // WAW: both write r7
      clear_inputs();
      set_slot(0, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 0);
      set_slot(1, 1, 5'd7, 1, 5'd3, 0, 5'd0, 0, 0);
      cyc();
      chk("waw_dq", 256'(last_dq), 256'(2'b01));

      // Load-use: ld.w r6 then a reader of r6 stalls once
      clear_inputs();
      set_slot(0, 1, 5'd6, 1, 5'd2, 0, 5'd0, 1, 0);
      cyc();
      set_slot(0, 1, 5'd9, 1, 5'd6, 0, 5'd0, 0, 0);
      cyc();
      chk("lu_dq", 256'(last_dq), 256'(2'b00));
      chk("lu_bubble", 256'(ex_valid), 256'(0));
      chk("lu_stall_cnt", 256'(perf_stall), 256'(1));
      cyc();
      chk("lu_issue", 256'(last_dq), 256'(2'b01));

      // Load to r0 then a read of r0: no stall
      clear_inputs();
      set_slot(0, 1, 5'd0, 1, 5'd2, 0, 5'd0, 1, 0);
      cyc();
      set_slot(0, 1, 5'd4, 1, 5'd0, 1, 5'd0, 0, 0);
      cyc();
      chk("lu_r0_dq", 256'(last_dq), 256'(2'b01));

      // Stall for three cycles with a flush on the last one
      clear_inputs();
      set_slot(0, 1, 5'd1, 1, 5'd3, 0, 5'd0, 0, 0);
      set_slot(1, 1, 5'd2, 1, 5'd4, 0, 5'd0, 0, 0);
      cyc();
      ex_stall = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) flush = 1;
         cyc();
         chk("stall_dq", 256'(last_dq), 256'(2'b00));
      end
      chk("stall_flush_valid", 256'(ex_valid), 256'(0));

      // Single-issue instructions
      clear_inputs();
      set_slot(0, 1, 5'd1, 1, 5'd3, 0, 5'd0, 0, 1);
      set_slot(1, 1, 5'd2, 1, 5'd4, 0, 5'd0, 0, 0);
      cyc();
      chk("single0_dq", 256'(last_dq), 256'(2'b01));
      id_single = 2'b10;
      cyc();
      chk("single1_dq", 256'(last_dq), 256'(2'b01));
      id_single = 2'b01; id_valid = 2'b01;
      cyc();
      chk("single1_next", 256'(last_dq), 256'(2'b01));

      // Valid pattern 10 is ignored
      clear_inputs();
      set_slot(1, 1, 5'd2, 1, 5'd4, 0, 5'd0, 0, 0);
      id_valid = 2'b10;
      cyc();
      chk("valid10_dq", 256'(last_dq), 256'(2'b00));

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         clear_inputs();
         for (int k = 0; k < 2; k++) begin
            set_slot(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
         end
         id_valid = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         flush    = ($urandom_range(0, 15) == 0);
         ex_stall = ($urandom_range(0, 5) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
